pmod_btn_unit: RTL
==================

# pmod_btn_unit

Input-side PMOD block for the IAGC board. It samples raw push-buttons on the PMOD header, synchronizes and debounces them, and turns each debounced press into a one-byte command. Commands go to the IAGC command path over a valid/ready handshake. It is the input counterpart to the PMOD LED status output and shares the same 100 MHz clock domain.

## Interface
Parameters:
- NB_BUTTONS, 4: number of button inputs (1–8).
- DEBOUNCE_TICKS, 1000000: cycles a synchronized level must stay stable before it is accepted (10 ms at 100 MHz); minimum 2.
- REPEAT_TICKS, 50000000: auto-repeat period while held (used only with PMOD_BTN_REPEAT_EN); minimum 2.
- CMD_SIZE, 8: command width.

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_btn  in  NB_BUTTONS  raw asynchronous buttons, active-high.
- i_cmd_ready  in  1  consumer accepts o_cmd this cycle.
- o_cmd_valid  out  1  o_cmd holds a command.
- o_cmd  out  CMD_SIZE  command code.
- o_btn_level  out  NB_BUTTONS  debounced button levels.

## Operation
- Synchronizer: a 2-FF chain per button. All stages reset to 0.
- Debounce, one counter per button:
  - If the synchronized value equals the debounced level, the counter is cleared to 0.
  - Otherwise the counter increments. On the cycle it equals DEBOUNCE_TICKS-1, the debounced level takes the synchronized value and the counter clears.
  - A glitch shorter than DEBOUNCE_TICKS cycles produces no level change.
- Press event: a 0→1 transition of a debounced level. Releases (1→0) generate nothing.
- Pending flags: one sticky bit per button.
  - A press event sets the bit.
  - Loading the button into the output clears the bit.
  - If a set and a clear hit the same bit in the same cycle, the set wins and no press is lost.
- Arbiter and output register:
  - The output register loads when it is empty, or when a transfer occurs this cycle (valid && ready).
  - It takes the lowest-index pending button i and sets o_cmd = 8'h30 + i (ASCII '0'+i, zero-extended/truncated to CMD_SIZE).
  - o_cmd_valid stays high and o_cmd stays stable until the consumer samples i_cmd_ready high.
  - Back-to-back transfers are supported, one per cycle.
- i_cmd_ready while o_cmd_valid is low has no effect.
- Presses of a button whose pending bit is already set merge into one command. There is at most one outstanding command per button.
- Reset mid-operation clears all state, including any in-flight command, which is dropped.
  - A button held through reset is seen as a fresh press after release of reset.
  - That press emits one command after the normal latency.

## Timing
- Reset values: o_cmd_valid=0, o_cmd=0, o_btn_level=0.
- All outputs are registered.
- Latency from the first clock edge on which i_btn is sampled at a new stable level:
  - 2 cycles synchronizer, then DEBOUNCE_TICKS cycles debounce, so o_btn_level changes at edge 2+DEBOUNCE_TICKS.
  - The pending bit sets on the next edge.
  - o_cmd_valid rises one edge later, at edge 4+DEBOUNCE_TICKS, provided the output register is free.
- Throughput: one command per cycle while i_cmd_ready=1 and flags are pending.
- Two buttons pressed in the same cycle produce two commands, lowest index first, on consecutive cycles when ready is held high.

## Configuration
- PMOD_BTN_REPEAT_EN defined:
  - A per-button repeat counter runs while the debounced level is 1.
  - Each time it reaches REPEAT_TICKS-1 it wraps to 0 and emits a press event, which sets the pending bit.
  - The counter clears when the level is 0, and on reset.
  - The first repeat occurs REPEAT_TICKS cycles after the debounced rise.
- Not defined: no repeat counters are instantiated, and a held button emits exactly one command.

## Test plan
All scenarios use DEBOUNCE_TICKS=4 and REPEAT_TICKS=16.
- Reset behaviour: hold i_reset 3 cycles with i_btn=4'b1111 → o_cmd_valid=0, o_cmd=0, o_btn_level=0 during reset. After release, one command per button (8'h30..8'h33) in index order.
- Single press: i_btn[2] 0→1 held, i_cmd_ready=1 → o_btn_level[2] rises at edge 6, o_cmd_valid=1 with o_cmd=8'h32 at edge 8 for one cycle. Release → no further command.
- Glitch rejection: i_btn[0] high for 3 cycles then low → o_btn_level stays 0, no command.
- Simultaneous presses with backpressure: i_btn[3] and i_btn[1] rise together, i_cmd_ready=0 for 10 cycles → o_cmd=8'h31 held stable. Then with ready=1 → 8'h31 then 8'h33 on consecutive cycles.
- Merging: press/release i_btn[0] twice (each phase 8 cycles) while ready=0 → exactly one 8'h30 after ready rises.
- Repeat (PMOD_BTN_REPEAT_EN): hold i_btn[1] for 60 cycles after the debounced rise with ready=1 → 8'h31 at the rise plus 3 repeats at 16-cycle spacing. Without the macro → exactly one 8'h31.

Source files
------------

// File: rtl/pmod_btn_unit.sv
// pmod_btn_unit
//   Input-side PMOD block. Raw push-buttons are synchronized (2-FF), debounced
//   per button, and each debounced press is turned into a one-byte command
//   ('0' + button index) delivered over a valid/ready handshake.
//
// Ports:
//   i_clock      system clock (100 MHz domain)
//   i_reset      synchronous, active-high reset
//   i_btn        raw asynchronous buttons, active-high
//   i_cmd_ready  consumer accepts o_cmd this cycle
//   o_cmd_valid  o_cmd holds a command
//   o_cmd        command code
//   o_btn_level  debounced button levels
//
// Build option:
//   PMOD_BTN_REPEAT_EN  when defined, a held button re-issues a press every
//                       REPEAT_TICKS cycles. When undefined, a held button
//                       emits exactly one command.
module pmod_btn_unit #(
  parameter int NB_BUTTONS     = 4,
  parameter int DEBOUNCE_TICKS = 1000000,
  parameter int REPEAT_TICKS   = 50000000,
  parameter int CMD_SIZE       = 8
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [NB_BUTTONS-1:0] i_btn,
  input  logic                  i_cmd_ready,
  output logic                  o_cmd_valid,
  output logic [CMD_SIZE-1:0]   o_cmd,
  output logic [NB_BUTTONS-1:0] o_btn_level
);

  localparam int DB_W  = $clog2(DEBOUNCE_TICKS);
  localparam int IDX_W = (NB_BUTTONS > 1) ? $clog2(NB_BUTTONS) : 1;

  logic [NB_BUTTONS-1:0] sync1_reg;
  logic [NB_BUTTONS-1:0] sync2_reg;
  logic [NB_BUTTONS-1:0] level_reg;
  logic [NB_BUTTONS-1:0] level_prev_reg;
  logic [NB_BUTTONS-1:0] repeat_event;
  logic [NB_BUTTONS-1:0] press;
  logic [NB_BUTTONS-1:0] held_mask;
  logic [NB_BUTTONS-1:0] pending_set;
  logic [NB_BUTTONS-1:0] pending_clr;
  logic [NB_BUTTONS-1:0] pending_reg;
  logic [NB_BUTTONS-1:0] pending_next;

  logic                  valid_reg;
  logic [CMD_SIZE-1:0]   cmd_reg;
  logic [IDX_W-1:0]      out_idx_reg;

  logic                  found;
  logic [IDX_W-1:0]      sel_idx;
  logic                  load;
  logic [CMD_SIZE-1:0]   cmd_code;

  // Two-stage synchronizer for the asynchronous button inputs.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      sync1_reg      <= '0;
      sync2_reg      <= '0;
      level_prev_reg <= '0;
    end else begin
      sync1_reg      <= i_btn;
      sync2_reg      <= sync1_reg;
      level_prev_reg <= level_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NB_BUTTONS; gi++) begin : g_btn
      logic [DB_W-1:0] db_cnt_reg;
      logic            lvl_reg;

      // Counter runs only while the synchronized input disagrees with the
      // accepted level; any return to agreement restarts the window.
      always_ff @(posedge i_clock) begin
        if (i_reset) begin
          db_cnt_reg <= '0;
          lvl_reg    <= 1'b0;
        end else if (sync2_reg[gi] == lvl_reg) begin
          db_cnt_reg <= '0;
        end else if (db_cnt_reg == DB_W'(DEBOUNCE_TICKS - 1)) begin
          lvl_reg    <= sync2_reg[gi];
          db_cnt_reg <= '0;
        end else begin
          db_cnt_reg <= db_cnt_reg + 1'b1;
        end
      end

      assign level_reg[gi] = lvl_reg;

`ifdef PMOD_BTN_REPEAT_EN
      localparam int RP_W = $clog2(REPEAT_TICKS);
      logic [RP_W-1:0] rp_cnt_reg;
      logic            rp_pulse_reg;

      // The wrap pulse is registered so that, like the rising-edge press,
      // it is seen one cycle after the counting cycle; this places repeats
      // exactly REPEAT_TICKS cycles apart from the initial press.
      always_ff @(posedge i_clock) begin
        if (i_reset || !lvl_reg) begin
          rp_cnt_reg   <= '0;
          rp_pulse_reg <= 1'b0;
        end else if (rp_cnt_reg == RP_W'(REPEAT_TICKS - 1)) begin
          rp_cnt_reg   <= '0;
          rp_pulse_reg <= 1'b1;
        end else begin
          rp_cnt_reg   <= rp_cnt_reg + 1'b1;
          rp_pulse_reg <= 1'b0;
        end
      end

      assign repeat_event[gi] = rp_pulse_reg;
`else
      localparam int unused_repeat_ticks = REPEAT_TICKS;
      assign repeat_event[gi] = 1'b0;
`endif
    end
  endgenerate

  assign press = (level_reg & ~level_prev_reg) | repeat_event;

  // A button whose command is sitting unaccepted in the output register is
  // already outstanding; further presses merge into that command.
  always_comb begin
    held_mask = '0;
    if (valid_reg && !i_cmd_ready) begin
      held_mask[out_idx_reg] = 1'b1;
    end
  end

  assign pending_set = press & ~held_mask;

  // Lowest-index pending button wins.
  always_comb begin
    found   = 1'b0;
    sel_idx = '0;
    for (int i = NB_BUTTONS - 1; i >= 0; i--) begin
      if (pending_reg[i]) begin
        found   = 1'b1;
        sel_idx = IDX_W'(i);
      end
    end
  end

  assign load     = !valid_reg || i_cmd_ready;
  assign cmd_code = CMD_SIZE'(8'h30 + 8'(sel_idx));

  // Set is applied after clear so a press coinciding with a load survives.
  always_comb begin
    pending_clr = '0;
    if (load && found) begin
      pending_clr[sel_idx] = 1'b1;
    end
    pending_next = (pending_reg & ~pending_clr) | pending_set;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      pending_reg <= '0;
      valid_reg   <= 1'b0;
      cmd_reg     <= '0;
      out_idx_reg <= '0;
    end else begin
      pending_reg <= pending_next;
      if (load) begin
        valid_reg <= found;
        if (found) begin
          cmd_reg     <= cmd_code;
          out_idx_reg <= sel_idx;
        end
      end
    end
  end

  assign o_cmd_valid = valid_reg;
  assign o_cmd       = cmd_reg;
  assign o_btn_level = level_reg;

endmodule
